wb_tmr_regfile: RTL

Wishbone-slave register file with triple-modular-redundant storage, the first stage inside the user project behind the management SoC Wishbone port. It holds NREGS 32-bit registers as three copies each. It returns the bitwise majority vote on reads and repairs upset copies with a background scrubber. Repairs are counted and flagged on an interrupt. A fault-injection port, driven from the logic analyzer, lets software and benches flip single bits.

---
 rtl/wb_tmr_regfile.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/wb_tmr_regfile.sv
// -----------------------------------------------------------------------------
// wb_tmr_regfile
//
// Wishbone classic slave register file with triple-modular-redundant storage.
// Each of NREGS 32-bit registers is held as three copies (A/B/C). Reads return
// the bitwise majority vote. Upset copies are repaired, counted in err_cnt and
// flagged on irq. A fault-injection port flips single bits for test.
//
// Build option:
//   TMR_SCRUB_EN defined   : a background scrubber walks one register per
//                            cycle and repairs any copy mismatch it finds.
//   TMR_SCRUB_EN undefined : no scrubber; a bus read of a data register
//                            repairs that register when its copies disagree.
//
// Address map (offset = wbs_adr_i[7:0], block selected by adr[31:8]):
//   0x00 .. 4*(NREGS-1) : data registers (index adr[5:2])
//   0x80                : STATUS  [15:0] err_cnt, [16] pend
//                         write with sel[2] & dat[16] clears both
//   other in-base       : read 0, writes dropped, still acked
//
// Ports:
//   wb_clk_i, wb_rst_i          clock, asynchronous active-high reset
//   wbs_cyc_i/stb_i/we_i        Wishbone classic controls
//   wbs_sel_i[3:0]              byte enables
//   wbs_adr_i[31:0]             byte address
//   wbs_dat_i[31:0]             write data
//   wbs_ack_o                   one-cycle acknowledge
//   wbs_dat_o[31:0]             read data, held until the next read
//   irq                         error-pending level (= pend)
//   inj_valid_i                 one-cycle fault-injection strobe
//   inj_copy_i[1:0]             copy to corrupt (3 = ignored)
//   inj_idx_i[3:0]              register index (>= NREGS ignored)
//   inj_bit_i[4:0]              bit to invert
// -----------------------------------------------------------------------------
module wb_tmr_regfile #(
  parameter int          NREGS    = 8,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq,
  input  logic        inj_valid_i,
  input  logic [1:0]  inj_copy_i,
  input  logic [3:0]  inj_idx_i,
  input  logic [4:0]  inj_bit_i
);

  localparam int IW = $clog2(NREGS);

  typedef logic [31:0] word_t;
  typedef enum logic {S_IDLE, S_ACK} state_t;

  function automatic word_t vote(input word_t a, input word_t b, input word_t c);
    return (a & b) | (b & c) | (a & c);
  endfunction

  word_t   mem_a [NREGS];
  word_t   mem_b [NREGS];
  word_t   mem_c [NREGS];
  word_t   na    [NREGS];
  word_t   nb    [NREGS];
  word_t   nc    [NREGS];

  state_t  state;
  logic [15:0] err_cnt;
  logic        pend;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic [7:0]    off;
  logic          adr_match, is_data, is_status, access;
  logic          bus_wr_data, status_clr;
  logic [IW-1:0] bus_idx;
  word_t         wmask;

  assign off         = wbs_adr_i[7:0];
  assign adr_match   = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign is_data     = (off[7:2] < 6'(NREGS));
  assign is_status   = (off[7:2] == 6'h20);
  assign bus_idx     = wbs_adr_i[IW+1:2];
  assign access      = (state == S_IDLE) && wbs_cyc_i && wbs_stb_i && adr_match;
  assign bus_wr_data = access && wbs_we_i && is_data;
  assign status_clr  = access && wbs_we_i && is_status && wbs_sel_i[2] && wbs_dat_i[16];
  assign wmask       = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                        {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  // Byte offset bits are don't-care for word registers.
  logic unused_adr_lsb;
  assign unused_adr_lsb = ^wbs_adr_i[1:0];

  // ---------------------------------------------------------------------------
  // Fault injection: a bus write to the same register wins and drops it.
  // ---------------------------------------------------------------------------
  logic          inj_ok, inj_eff;
  logic [IW-1:0] inj_r;
  word_t         inj_mask;

  assign inj_ok   = inj_valid_i && (inj_copy_i != 2'd3) && ({1'b0, inj_idx_i} < 5'(NREGS));
  assign inj_r    = inj_idx_i[IW-1:0];
  assign inj_eff  = inj_ok && !(bus_wr_data && (bus_idx == inj_r));
  assign inj_mask = word_t'(1) << inj_bit_i;

  // ---------------------------------------------------------------------------
  // Repair source: scrubber pointer or the register being read.
  // ---------------------------------------------------------------------------
  logic          repair;
  logic [IW-1:0] rep_idx;

`ifdef TMR_SCRUB_EN
  logic [IW-1:0] sp;
  logic          sp_blocked;

  // A bus write or injection on the scrubbed register wins; sp then holds
  // so the same register is examined again next cycle.
  assign sp_blocked = (bus_wr_data && (bus_idx == sp)) || (inj_ok && (inj_r == sp));
  assign rep_idx    = sp;
  assign repair     = !sp_blocked &&
                      ((mem_a[sp] != mem_b[sp]) || (mem_b[sp] != mem_c[sp]));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)         sp <= '0;
    else if (!sp_blocked) sp <= sp + IW'(1);
  end
`else
  logic bus_rd_data;

  assign bus_rd_data = access && !wbs_we_i && is_data;
  assign rep_idx     = bus_idx;
  assign repair      = bus_rd_data && !(inj_ok && (inj_r == bus_idx)) &&
                       ((mem_a[bus_idx] != mem_b[bus_idx]) ||
                        (mem_b[bus_idx] != mem_c[bus_idx]));
`endif

  // ---------------------------------------------------------------------------
  // Next-state of the three copies, priority: bus write, injection, repair.
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      // NOTE: every array element gets its current value first, so no path
      // through this block leaves a variable unassigned and no latch is inferred.
      na[i] = mem_a[i];
      nb[i] = mem_b[i];
      nc[i] = mem_c[i];
      if (bus_wr_data && (bus_idx == IW'(i))) begin
        na[i] = (mem_a[i] & ~wmask) | (wbs_dat_i & wmask);
        nb[i] = (mem_b[i] & ~wmask) | (wbs_dat_i & wmask);
        nc[i] = (mem_c[i] & ~wmask) | (wbs_dat_i & wmask);
      end else if (inj_eff && (inj_r == IW'(i))) begin
        case (inj_copy_i)
          2'd0:    na[i] = mem_a[i] ^ inj_mask;
          2'd1:    nb[i] = mem_b[i] ^ inj_mask;
          2'd2:    nc[i] = mem_c[i] ^ inj_mask;
          default: ;
        endcase
      end else if (repair && (rep_idx == IW'(i))) begin
        na[i] = vote(mem_a[i], mem_b[i], mem_c[i]);
        nb[i] = na[i];
        nc[i] = na[i];
      end
    end
  end

  // Read data is voted over the post-injection copies; a repair of the same
  // register does not change the vote.
  word_t rd_mux;
  always_comb begin
    rd_mux = '0;
    if (is_data)        rd_mux = vote(na[bus_idx], nb[bus_idx], nc[bus_idx]);
    else if (is_status) rd_mux = {15'd0, pend, err_cnt};
  end

  // ---------------------------------------------------------------------------
  // Storage, error counter and pending flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      // NOTE: the copies are reset explicitly because software relies on every
      // register reading 0 after reset; this forces flops rather than a RAM macro.
      for (int i = 0; i < NREGS; i++) begin
        mem_a[i] <= '0;
        mem_b[i] <= '0;
        mem_c[i] <= '0;
      end
      err_cnt <= '0;
      pend    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      mem_a <= na;
      mem_b <= nb;
      mem_c <= nc;
      if (status_clr) begin
        // A repair coinciding with the clear is kept as the first new error.
        err_cnt <= repair ? 16'd1 : 16'd0;
        pend    <= repair;
      end else if (repair) begin
        if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
        pend <= 1'b1;
      end
    end
  end

  assign irq = pend;

  // ---------------------------------------------------------------------------
  // Bus FSM: IDLE accepts, ACK acknowledges for exactly one cycle.
  // ---------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= S_IDLE;
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) begin
            wbs_ack_o <= 1'b1;
            state     <= S_ACK;
            if (!wbs_we_i) wbs_dat_o <= rd_mux;
          end
        end
        S_ACK: begin
          wbs_ack_o <= 1'b0;
          state     <= S_IDLE;
        end
        default: begin
          wbs_ack_o <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule
